matrix_write_arbiter: RTL and testbench
=======================================

Name: matrix_write_arbiter

Overview:
- Shares the single matrix-storage write port between two session-oriented writers: port 0, the input controller (manual/auto entry), and port 1, the compute result writeback.
- Grants whole write sessions (set-dims, then elements). Muxes the granted writer's bus to storage and allocates the target slot ID.
- Aborts sessions on release or timeout.
- Sits between the writers and matrix storage.

Parameters:
- NUM_SLOTS, 8, number of storage slots; slot IDs wrap at NUM_SLOTS-1 (must be ≤ 2^MAT_ID_W).
- TIMEOUT_CYC, 1_000_000, idle cycles within a granted session before abort.
- TO_W, $clog2(TIMEOUT_CYC+1), timeout counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  2  per-port session request; level, held for the whole session
- last  in  2  per-port; qualifies that port's wr_en as the final write of its session
- in_wr_en  in  2  per-port write strobe
- in_cmd_set_dims  in  2  per-port dims command
- in_cmd_single  in  2  per-port single-element command
- in_dims_r  in  2xROW_IDX_W  per-port row count
- in_dims_c  in  2xCOL_IDX_W  per-port column count
- in_row_idx  in  2xROW_IDX_W  per-port row index
- in_col_idx  in  2xCOL_IDX_W  per-port column index
- in_data  in  2xmatrix_element_t  per-port element
- gnt  out  2  one-hot session grant, registered
- wr_en, wr_cmd_set_dims, wr_cmd_single  out  1 each  storage write bus
- wr_dims_r, wr_row_idx  out  ROW_IDX_W  storage write bus
- wr_dims_c, wr_col_idx  out  COL_IDX_W  storage write bus
- wr_data  out  matrix_element_t  storage write bus
- wr_slot_id  out  MAT_ID_W  slot for the current session
- sess_done  out  1  pulse on normal session completion
- done_slot_id  out  MAT_ID_W  slot just completed; valid with sess_done
- sess_abort  out  1  pulse on abort
- timeout_err  out  1  pulse; accompanies sess_abort when the cause is timeout
- drop_err  out  1  pulse; non-granted port asserted in_wr_en (write discarded)

Behaviour:
Reset:
- State IDLE.
- gnt=0, all wr_* = 0, slot counter = 0, priority pointer = 0.
- All pulses 0, timeout counter 0.
- Reset mid-session discards the session silently; no sess_abort is issued.

State machine (states IDLE, GNT0, GNT1):
- IDLE, single req: go to that port's GNTn next cycle; gnt[n] asserted.
- IDLE, both req: grant the port equal to the priority pointer.
- On grant: wr_slot_id latched from the slot counter; timeout counter cleared.
- GNTn, write bus: combinational pass-through of port n's fields, AND-gated by gnt[n]. Zero latency from in_* to wr_*.
- GNTn, normal end: in_wr_en[n] && last[n] passes through that cycle. Next cycle:
  - state IDLE, gnt=0;
  - sess_done=1 with done_slot_id = latched slot;
  - slot counter +1, wrapping NUM_SLOTS-1 → 0;
  - priority pointer = other port.
- GNTn, release: req[n] falls without last → IDLE next cycle, sess_abort=1. Slot counter unchanged; pointer flips.
- GNTn, timeout: counter increments each cycle without in_wr_en[n] and clears on each in_wr_en[n]. Reaching TIMEOUT_CYC → IDLE next cycle, sess_abort=1, timeout_err=1. Slot counter unchanged; pointer flips.
- Precedence in the same cycle: last-write > release > timeout.
- Sessions are separated by at least one IDLE cycle. A port holding req after completion is regranted only if the other port is not requesting.

Boundaries and errors:
- drop_err: asserted for one cycle when in_wr_en is high on a non-granted port, or on any port in IDLE. That write never reaches storage.
- last without in_wr_en: ignored.

Decomposition:
- project_pkg already supplies matrix_element_t, ROW_IDX_W, COL_IDX_W and MAT_ID_W.
- Add to project_pkg: arb_state_t enum (ARB_IDLE, ARB_GNT0, ARB_GNT1) and ARB_TIMEOUT_DEFAULT.
- One natural sub-module: arb_session_timer (loadable clear, terminal-count pulse), reusable by the input FSMs.

Test Plan:
- Single session: req[0]=1, one set_dims 2x2, 4 singles, last on the 4th → gnt[0] one cycle after req. wr_* mirrors port 0 with zero latency. sess_done with done_slot_id=0; next session gets slot 1.
- Contention: req=2'b11 from IDLE after reset → port 0 granted. After its last write: 1 IDLE cycle, then gnt[1]. Completion slots are 0 then 1.
- Drop: during GNT0, in_wr_en[1]=1 with data 8'h55 → drop_err pulse. Storage wr_en follows port 0 only; 8'h55 never appears on wr_data.
- Abort/timeout: TIMEOUT_CYC=16, grant port 1, no writes for 16 cycles → sess_abort and timeout_err pulse; next session still gets slot 0. Separately, dropping req mid-session → sess_abort only.
- Wrap: NUM_SLOTS=3, four completed sessions → done_slot_id sequence 0,1,2,0.
- Reset mid-session: assert rst during GNT0 after 2 writes → gnt=0 and wr_en=0 immediately, no sess_abort. After release, the first session gets slot 0.

Source files
------------

// File: rtl/project_pkg.sv
// Shared matrix types and widths, plus the write-arbiter state encoding and write-bus payload.
package project_pkg;

  localparam int unsigned ROW_IDX_W = 4;
  localparam int unsigned COL_IDX_W = 4;
  localparam int unsigned MAT_ID_W  = 3;
  localparam int unsigned ELEM_W    = 8;

  typedef logic [ELEM_W-1:0] matrix_element_t;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  // One writer's storage-bus fields, muxed as a unit
  typedef struct packed {
    logic                 wr_en;
    logic                 cmd_set_dims;
    logic                 cmd_single;
    logic [ROW_IDX_W-1:0] dims_r;
    logic [COL_IDX_W-1:0] dims_c;
    logic [ROW_IDX_W-1:0] row_idx;
    logic [COL_IDX_W-1:0] col_idx;
    matrix_element_t      data;
  } wr_bus_t;

endpackage

// File: rtl/matrix_write_arbiter_if.sv
// Writer-side request/bus signals and the arbitrated storage write bus.
interface matrix_write_arbiter_if;
  import project_pkg::*;

  logic [1:0]                 req;
  logic [1:0]                 last;
  logic [1:0]                 in_wr_en;
  logic [1:0]                 in_cmd_set_dims;
  logic [1:0]                 in_cmd_single;
  logic [1:0][ROW_IDX_W-1:0]  in_dims_r;
  logic [1:0][COL_IDX_W-1:0]  in_dims_c;
  logic [1:0][ROW_IDX_W-1:0]  in_row_idx;
  logic [1:0][COL_IDX_W-1:0]  in_col_idx;
  matrix_element_t [1:0]      in_data;

  logic [1:0]                 gnt;
  logic                       wr_en;
  logic                       wr_cmd_set_dims;
  logic                       wr_cmd_single;
  logic [ROW_IDX_W-1:0]       wr_dims_r;
  logic [COL_IDX_W-1:0]       wr_dims_c;
  logic [ROW_IDX_W-1:0]       wr_row_idx;
  logic [COL_IDX_W-1:0]       wr_col_idx;
  matrix_element_t            wr_data;
  logic [MAT_ID_W-1:0]        wr_slot_id;
  logic                       sess_done;
  logic [MAT_ID_W-1:0]        done_slot_id;
  logic                       sess_abort;
  logic                       timeout_err;
  logic                       drop_err;

  modport slave (
    input  req, last, in_wr_en, in_cmd_set_dims, in_cmd_single,
           in_dims_r, in_dims_c, in_row_idx, in_col_idx, in_data,
    output gnt, wr_en, wr_cmd_set_dims, wr_cmd_single, wr_dims_r, wr_dims_c,
           wr_row_idx, wr_col_idx, wr_data, wr_slot_id, sess_done, done_slot_id,
           sess_abort, timeout_err, drop_err
  );

  modport master (
    output req, last, in_wr_en, in_cmd_set_dims, in_cmd_single,
           in_dims_r, in_dims_c, in_row_idx, in_col_idx, in_data,
    input  gnt, wr_en, wr_cmd_set_dims, wr_cmd_single, wr_dims_r, wr_dims_c,
           wr_row_idx, wr_col_idx, wr_data, wr_slot_id, sess_done, done_slot_id,
           sess_abort, timeout_err, drop_err
  );

endinterface

// File: rtl/matrix_write_arbiter_timer.sv
// Idle-cycle session timer: clear reloads zero, expire_c flags the cycle the count reaches TIMEOUT_CYC.
module arb_session_timer
  import project_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] count_q;

  assign expire_c = enable && !clear && (count_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != TO_W'(TIMEOUT_CYC))) begin
      count_q <= count_q + TO_W'(1);
    end
  end

endmodule

// File: rtl/matrix_write_arbiter.sv
// Session arbiter for the shared matrix-storage write port: port 0 input controller, port 1 writeback.
module matrix_write_arbiter
  import project_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 8,
  parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_write_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'(ARB_IDLE);
  localparam logic [1:0] ST_GNT0 = 2'(ARB_GNT0);
  localparam logic [1:0] ST_GNT1 = 2'(ARB_GNT1);

  logic [1:0]          state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                ptr_q, ptr_d;
  logic [MAT_ID_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [MAT_ID_W-1:0] slot_id_q, slot_id_d;
  logic [MAT_ID_W-1:0] done_slot_q, done_slot_d;
  logic                done_q, done_d, abort_q, abort_d;
  logic                to_q, to_d, drop_q, drop_d;
  logic                cur, own_wr, expire_c;
  wr_bus_t             sel;

  assign cur    = (state_q == ST_GNT1);
  assign own_wr = |(bus.in_wr_en & gnt_q);

  arb_session_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state_q == ST_IDLE) || own_wr),
    .enable   (state_q != ST_IDLE),
    .expire_c (expire_c)
  );

  // Zero-latency pass-through of the granted writer; nothing leaks without a grant
  always_comb begin
    sel = '0;
    for (int p = 0; p < 2; p++) begin
      if (gnt_q[p]) begin
        sel.wr_en        = bus.in_wr_en[p];
        sel.cmd_set_dims = bus.in_cmd_set_dims[p];
        sel.cmd_single   = bus.in_cmd_single[p];
        sel.dims_r       = bus.in_dims_r[p];
        sel.dims_c       = bus.in_dims_c[p];
        sel.row_idx      = bus.in_row_idx[p];
        sel.col_idx      = bus.in_col_idx[p];
        sel.data         = bus.in_data[p];
      end
    end
  end

  assign bus.wr_en           = sel.wr_en;
  assign bus.wr_cmd_set_dims = sel.cmd_set_dims;
  assign bus.wr_cmd_single   = sel.cmd_single;
  assign bus.wr_dims_r       = sel.dims_r;
  assign bus.wr_dims_c       = sel.dims_c;
  assign bus.wr_row_idx      = sel.row_idx;
  assign bus.wr_col_idx      = sel.col_idx;
  assign bus.wr_data         = sel.data;

  // Next state; session end priority is last-write, then release, then timeout
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    slot_cnt_d  = slot_cnt_q;
    slot_id_d   = slot_id_q;
    done_slot_d = done_slot_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    to_d        = 1'b0;
    drop_d      = |(bus.in_wr_en & ~gnt_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.req == 2'b11) begin
          state_d   = ptr_q ? ST_GNT1 : ST_GNT0;
          slot_id_d = slot_cnt_q;
        end else if (bus.req[0]) begin
          state_d   = ST_GNT0;
          slot_id_d = slot_cnt_q;
        end else if (bus.req[1]) begin
          state_d   = ST_GNT1;
          slot_id_d = slot_cnt_q;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (bus.in_wr_en[cur] && bus.last[cur]) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          done_slot_d = slot_id_q;
          ptr_d       = ~cur;
          slot_cnt_d  = (slot_cnt_q == MAT_ID_W'(NUM_SLOTS - 1)) ? '0
                                                                  : slot_cnt_q + MAT_ID_W'(1);
        end else if (!bus.req[cur]) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
          ptr_d   = ~cur;
        end else if (expire_c) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
          to_d    = 1'b1;
          ptr_d   = ~cur;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    gnt_d = {state_d == ST_GNT1, state_d == ST_GNT0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      ptr_q       <= 1'b0;
      slot_cnt_q  <= '0;
      slot_id_q   <= '0;
      done_slot_q <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      to_q        <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      slot_cnt_q  <= slot_cnt_d;
      slot_id_q   <= slot_id_d;
      done_slot_q <= done_slot_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      to_q        <= to_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.wr_slot_id   = slot_id_q;
  assign bus.sess_done    = done_q;
  assign bus.done_slot_id = done_slot_q;
  assign bus.sess_abort   = abort_q;
  assign bus.timeout_err  = to_q;
  assign bus.drop_err     = drop_q;

endmodule

// File: tb/tb_matrix_write_arbiter.sv
// Bench for matrix_write_arbiter: directed vector table, hand sequences for timeout/release/wrap/reset,
// and random traffic against a session-level reference model.
module tb_matrix_write_arbiter;
  import project_pkg::*;

  localparam int NS = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_write_arbiter_if bus();

  matrix_write_arbiter #(.NUM_SLOTS(NS), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the port, which slot is next, whose turn it is
  int m_owner, m_slot, m_sess, m_ptr, m_idle, m_done_slot;
  bit m_done, m_abort, m_to, m_drop;

  typedef struct {
    logic [1:0] req, wr, last, sd, sg;
    logic [7:0] d0, d1;
    logic [1:0] e_gnt;
    logic       e_wr_en;
    logic [7:0] e_data;
    logic       e_done;
    logic [2:0] e_slot;
    logic       e_abort, e_drop;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_slot = 0; m_sess = 0; m_ptr = 0; m_idle = 0; m_done_slot = 0;
    m_done = 0; m_abort = 0; m_to = 0; m_drop = 0;
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] wr, input logic [1:0] ls,
                       input logic [1:0] sd, input logic [1:0] sg,
                       input matrix_element_t d0, input matrix_element_t d1);
    bus.req             = rq;
    bus.in_wr_en        = wr;
    bus.last            = ls;
    bus.in_cmd_set_dims = sd;
    bus.in_cmd_single   = sg;
    bus.in_data[0]      = d0;
    bus.in_data[1]      = d1;
    for (int p = 0; p < 2; p++) begin
      bus.in_dims_r[p]  = ROW_IDX_W'($urandom);
      bus.in_dims_c[p]  = COL_IDX_W'($urandom);
      bus.in_row_idx[p] = ROW_IDX_W'($urandom);
      bus.in_col_idx[p] = COL_IDX_W'($urandom);
    end
  endtask

  task automatic check_model();
    wr_bus_t    eb, ab;
    logic [1:0] eg;
    eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    eb = '0;
    if (m_owner >= 0) begin
      eb.wr_en        = bus.in_wr_en[m_owner];
      eb.cmd_set_dims = bus.in_cmd_set_dims[m_owner];
      eb.cmd_single   = bus.in_cmd_single[m_owner];
      eb.dims_r       = bus.in_dims_r[m_owner];
      eb.dims_c       = bus.in_dims_c[m_owner];
      eb.row_idx      = bus.in_row_idx[m_owner];
      eb.col_idx      = bus.in_col_idx[m_owner];
      eb.data         = bus.in_data[m_owner];
    end
    ab.wr_en        = bus.wr_en;
    ab.cmd_set_dims = bus.wr_cmd_set_dims;
    ab.cmd_single   = bus.wr_cmd_single;
    ab.dims_r       = bus.wr_dims_r;
    ab.dims_c       = bus.wr_dims_c;
    ab.row_idx      = bus.wr_row_idx;
    ab.col_idx      = bus.wr_col_idx;
    ab.data         = bus.wr_data;
    chk("gnt", 64'(bus.gnt), 64'(eg));
    chk("wr_bus", 64'(ab), 64'(eb));
    if (m_owner >= 0) chk("wr_slot_id", 64'(bus.wr_slot_id), 64'(m_sess));
    chk("sess_done", 64'(bus.sess_done), 64'(m_done));
    if (m_done) chk("done_slot_id", 64'(bus.done_slot_id), 64'(m_done_slot));
    chk("sess_abort", 64'(bus.sess_abort), 64'(m_abort));
    chk("timeout_err", 64'(bus.timeout_err), 64'(m_to));
    chk("drop_err", 64'(bus.drop_err), 64'(m_drop));
  endtask

  task automatic model_update();
    int o;
    m_done = 0; m_abort = 0; m_to = 0; m_drop = 0;
    for (int p = 0; p < 2; p++)
      if (bus.in_wr_en[p] && p != m_owner) m_drop = 1;
    if (m_owner < 0) begin
      if (bus.req == 2'b11)  m_owner = m_ptr;
      else if (bus.req[0])   m_owner = 0;
      else if (bus.req[1])   m_owner = 1;
      if (m_owner >= 0) begin
        m_sess = m_slot;
        m_idle = 0;
      end
    end else begin
      o = m_owner;
      if (bus.in_wr_en[o] && bus.last[o]) begin
        m_done = 1; m_done_slot = m_sess; m_slot = (m_slot + 1) % NS;
        m_ptr = 1 - o; m_owner = -1;
      end else if (!bus.req[o]) begin
        m_abort = 1; m_ptr = 1 - o; m_owner = -1;
      end else if (bus.in_wr_en[o]) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle >= TO) begin
          m_abort = 1; m_to = 1; m_ptr = 1 - o; m_owner = -1;
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [1:0] rq, input logic [1:0] wr, input logic [1:0] ls,
                       input logic [1:0] sd, input logic [1:0] sg,
                       input matrix_element_t d0, input matrix_element_t d1);
    drive(rq, wr, ls, sd, sg, d0, d1);
    #2;
    check_model();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_slot_id", 64'(bus.wr_slot_id), 64'd0);
    chk("rst_pulses", 64'({bus.sess_done, bus.sess_abort, bus.timeout_err, bus.drop_err}), 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // One-write session on port p; returns the completion slot the DUT reports
  task automatic do_session(input int p, output logic [2:0] slot);
    logic [1:0] rq;
    rq = 2'b01 << p;
    cycle(rq, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    cycle(rq, rq, rq, 2'b00, rq, 8'($urandom), 8'($urandom));
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    #2;
    check_model();
    chk("session_done", 64'(bus.sess_done), 64'd1);
    slot = bus.done_slot_id;
    tick();
  endtask

  initial begin
    logic [2:0] slot;
    logic [2:0] wrap_exp [4];
    int pct;
    logic [1:0] rq, wr, ls;

    //          req    wr     last   sd     sg     d0     d1     gnt    we    data   done  slot  ab    drop
    tbl[0]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 8'h10, 8'h00, 2'b01, 1'b1, 8'h10, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 8'h11, 8'h00, 2'b01, 1'b1, 8'h11, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[3]  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 8'h12, 8'h00, 2'b01, 1'b1, 8'h12, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[4]  = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 8'h13, 8'h55, 2'b01, 1'b1, 8'h13, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[5]  = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 8'h14, 8'h00, 2'b01, 1'b1, 8'h14, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[6]  = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0};
    tbl[7]  = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 8'h00, 8'h20, 2'b10, 1'b1, 8'h20, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[8]  = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 8'h00, 8'h21, 2'b10, 1'b1, 8'h21, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
    wrap_exp[0] = 3'd0; wrap_exp[1] = 3'd1; wrap_exp[2] = 3'd2; wrap_exp[3] = 3'd0;

    // Directed table: single session with a dropped write, then regrant to the other port
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].req, tbl[i].wr, tbl[i].last, tbl[i].sd, tbl[i].sg, tbl[i].d0, tbl[i].d1);
      #2;
      check_model();
      chk($sformatf("tbl%0d_gnt", i), 64'(bus.gnt), 64'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d_wr_en", i), 64'(bus.wr_en), 64'(tbl[i].e_wr_en));
      chk($sformatf("tbl%0d_wr_data", i), 64'(bus.wr_data), 64'(tbl[i].e_data));
      chk($sformatf("tbl%0d_done", i), 64'(bus.sess_done), 64'(tbl[i].e_done));
      chk($sformatf("tbl%0d_abort", i), 64'(bus.sess_abort), 64'(tbl[i].e_abort));
      chk($sformatf("tbl%0d_drop", i), 64'(bus.drop_err), 64'(tbl[i].e_drop));
      if (tbl[i].e_done) chk($sformatf("tbl%0d_slot", i), 64'(bus.done_slot_id), 64'(tbl[i].e_slot));
      tick();
    end

    // Contention straight out of reset: port 0 first, one idle cycle, then port 1
    do_reset();
    drive(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00); #2; check_model();
    chk("cont_idle_gnt", 64'(bus.gnt), 64'd0); tick();
    drive(2'b11, 2'b01, 2'b01, 2'b00, 2'b01, 8'hA1, 8'h00); #2; check_model();
    chk("cont_gnt0", 64'(bus.gnt), 64'b01); tick();
    drive(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00); #2; check_model();
    chk("cont_gap_gnt", 64'(bus.gnt), 64'd0);
    chk("cont_slot0", 64'(bus.done_slot_id), 64'd0); tick();
    drive(2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 8'h00, 8'hB2); #2; check_model();
    chk("cont_gnt1", 64'(bus.gnt), 64'b10); tick();
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00); #2; check_model();
    chk("cont_slot1", 64'(bus.done_slot_id), 64'd1); tick();

    // Timeout on port 1: 16 idle granted cycles, then abort with timeout_err
    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive((i <= 16) ? 2'b10 : 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
      #2;
      check_model();
      if (i == 16) chk("to_still_gnt", 64'(bus.gnt), 64'b10);
      if (i == 17) begin
        chk("to_abort", 64'(bus.sess_abort), 64'd1);
        chk("to_err", 64'(bus.timeout_err), 64'd1);
        chk("to_gnt_clear", 64'(bus.gnt), 64'd0);
      end
      tick();
    end
    do_session(0, slot);
    chk("to_next_slot", 64'(slot), 64'd0);

    // Release mid-session: abort without timeout_err, slot counter unchanged
    cycle(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    cycle(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 8'h33, 8'h00);
    cycle(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00); #2; check_model();
    chk("rel_abort", 64'(bus.sess_abort), 64'd1);
    chk("rel_no_to", 64'(bus.timeout_err), 64'd0);
    tick();
    do_session(1, slot);
    chk("rel_next_slot", 64'(slot), 64'd1);

    // Slot wrap with three slots
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_session(i % 2, slot);
      chk($sformatf("wrap%0d_slot", i), 64'(slot), 64'(wrap_exp[i]));
    end

    // Asynchronous reset during a session: grant and bus drop at once, no abort
    cycle(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    cycle(2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 8'h40, 8'h00);
    cycle(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 8'h41, 8'h00);
    drive(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 8'h42, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 64'(bus.gnt), 64'd0);
    chk("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("mid_rst_abort", 64'(bus.sess_abort), 64'd0);
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #2;
    chk("post_rst_abort", 64'(bus.sess_abort), 64'd0);
    @(posedge clk); #1;
    do_session(0, slot);
    chk("post_rst_slot", 64'(slot), 64'd0);

    // Random traffic against the model, varying write density to provoke timeouts
    do_reset();
    rq = 2'b00;
    pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) pct = (i % 750 == 0) ? 4 : ((i % 500 == 0) ? 40 : 80);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(99) < 6) rq[p] = ~rq[p];
        wr[p] = ($urandom_range(99) < pct);
        ls[p] = ($urandom_range(99) < 20);
      end
      cycle(rq, wr, ls, 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
